// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, response FIFO, redirect flush.
// Optional ebreak halt when IFU_EBREAK_HALT_EN is defined.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CPU_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [CPU_WIDTH-1:0] imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  output logic                 halted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [CPU_WIDTH-1:0] fetch_pc;
  logic [CPU_WIDTH-1:0] rsp_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        count;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;

  logic [CPU_WIDTH-1:0] buf_data [FIFO_DEPTH];
  logic [CPU_WIDTH-1:0] buf_pc   [FIFO_DEPTH];

  logic                 halt_q;
  logic                 halt_set;
  logic                 redir;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 drop_dec;
  logic [CW:0]          used;
  logic [CW-1:0]        out_next;
  logic [CPU_WIDTH-1:0] target;
  logic [CPU_WIDTH-1:0] head_data;
  logic                 unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign target      = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
  assign head_data   = buf_data[rd_ptr];

  // Credit: buffered words plus words in flight never exceed the FIFO.
  assign used           = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !halt_q && (used < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign inst_valid = (count != '0) && !halt_q;
  assign inst       = inst_valid ? head_data : '0;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr] : '0;
  assign pop        = inst_valid && inst_ready;

  assign redir    = redirect_valid && !halt_q;
  assign drop_dec = imem_rsp_valid && (drop_cnt != '0);
  assign push     = imem_rsp_valid && (drop_cnt == '0)
                 && !redir && !halt_q && !halt_set;
  assign out_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);

`ifdef IFU_EBREAK_HALT_EN
  localparam logic [CPU_WIDTH-1:0] EBREAK = CPU_WIDTH'(32'h0010_0073);

  assign halt_set = pop && (head_data == EBREAK);

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (halt_set) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_set = 1'b0;
  assign halt_q   = 1'b0;
`endif

  assign halted = halt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= CPU_WIDTH'(RESET_PC);
      rsp_pc      <= CPU_WIDTH'(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      if (accept) begin
        fetch_pc <= fetch_pc + CPU_WIDTH'(4);
      end
      if (redir) begin
        // In-flight words after this edge all belong to the old path.
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= out_next;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else if (halt_q || halt_set) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (drop_dec) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + CPU_WIDTH'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a one-cycle instruction memory model.
// Memory word = address ^ 5A5A_1234, except eb_addr which returns ebreak.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic        mem_go;
  logic [31:0] eb_addr;
  logic [31:0] pq [$];
  int          pq_n = 0;
  logic [31:0] pq_head = '0;
  logic [31:0] iss [$];
  logic [31:0] con_pc [$];
  logic [31:0] con_d [$];

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == eb_addr) ? 32'h0010_0073 : (a ^ 32'h5A5A_1234);
  endfunction

  assign imem_rsp_valid = mem_go && (pq_n != 0);
  assign imem_rsp_data  = pq_head;

  always @(posedge clk) begin
    if (rst) begin
      pq.delete();
    end else begin
      if (imem_rsp_valid) void'(pq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pq.push_back(imem_req_addr);
        iss.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) begin
        con_pc.push_back(inst_pc);
        con_d.push_back(inst);
      end
    end
    pq_n    <= pq.size();
    pq_head <= (pq.size() != 0) ? word(pq[0]) : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    iss.delete();
    con_pc.delete();
    con_d.delete();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_go         = 1'b1;
    tick();
    tick();
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    int   n;
    eb_addr = 32'h1;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", imem_req_addr, 32'h8000_0000);

    // T1: streaming fetch, 2-cycle latency
    rst = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("t1_c0_req_valid", imem_req_valid, 1);
    chk("t1_c0_addr", imem_req_addr, 32'h8000_0000);
    tick();
    chk("t1_c1_inst_valid", inst_valid, 0);
    chk("t1_c1_addr", imem_req_addr, 32'h8000_0004);
    tick();
    chk("t1_c2_inst_valid", inst_valid, 1);
    chk("t1_c2_inst_pc", inst_pc, 32'h8000_0000);
    chk("t1_c2_inst", inst, word(32'h8000_0000));
    repeat (10) tick();
    chk("t1_iss0", iss[0], 32'h8000_0000);
    chk("t1_iss1", iss[1], 32'h8000_0004);
    chk("t1_iss2", iss[2], 32'h8000_0008);
    chk("t1_ncon", 32'(con_pc.size() >= 4), 1);
    for (int k = 0; k < con_pc.size(); k++) begin
      chk("t1_con_pc", con_pc[k], 32'h8000_0000 + 32'(4 * k));
      chk("t1_con_d", con_d[k], word(32'h8000_0000 + 32'(4 * k)));
    end

    // T2: backpressure stops after FIFO_DEPTH requests
    do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    repeat (8) tick();
    chk("t2_niss", 32'(iss.size()), 2);
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_inst_valid", inst_valid, 1);
    chk("t2_inst_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    repeat (12) tick();
    chk("t2_iss2", iss[2], 32'h8000_0008);
    chk("t2_ncon", 32'(con_pc.size() >= 4), 1);
    for (int k = 0; k < con_pc.size(); k++) begin
      chk("t2_con_pc", con_pc[k], 32'h8000_0000 + 32'(4 * k));
      chk("t2_con_d", con_d[k], word(32'h8000_0000 + 32'(4 * k)));
    end

    // T3: redirect with two requests in flight
    do_reset();
    mem_go = 1'b0;
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("t3_addr_tgt", imem_req_addr, 32'h8000_0010);
    tick();
    tick();
    chk("t3_req_blocked", imem_req_valid, 0);
    chk("t3_niss", 32'(iss.size()), 2);
    chk("t3_iss1", iss[1], 32'h8000_0014);
    chk("t3_inst_valid", inst_valid, 0);
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0101;
    inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    mem_go = 1'b1;
    chk("t3_addr_redir", imem_req_addr, 32'h8000_0100);
    chk("t3_req_wait", imem_req_valid, 0);
    repeat (12) tick();
    chk("t3_iss0", iss[0], 32'h8000_0100);
    chk("t3_con_pc0", con_pc[0], 32'h8000_0100);
    chk("t3_con_d0", con_d[0], word(32'h8000_0100));
    chk("t3_con_pc1", con_pc[1], 32'h8000_0104);

    // T4: redirect coincides with accept and response
    do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("t4_rsp_here", imem_rsp_valid, 1);
    chk("t4_req_here", imem_req_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t4_c2_inst_valid", inst_valid, 0);
    chk("t4_c2_addr", imem_req_addr, 32'h8000_0200);
    tick();
    chk("t4_c3_inst_valid", inst_valid, 0);
    repeat (10) tick();
    chk("t4_iss1", iss[1], 32'h8000_0004);
    chk("t4_iss2", iss[2], 32'h8000_0200);
    chk("t4_con_pc0", con_pc[0], 32'h8000_0200);
    chk("t4_con_d0", con_d[0], word(32'h8000_0200));

    // T5: address wrap
    do_reset();
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_addr_wrap", imem_req_addr, 32'h0000_0000);
    repeat (8) tick();
    chk("t5_con_pc0", con_pc[0], 32'hFFFF_FFFC);
    chk("t5_con_pc1", con_pc[1], 32'h0000_0000);
    chk("t5_con_pc2", con_pc[2], 32'h0000_0004);
    chk("t5_con_d1", con_d[1], word(32'h0000_0000));

    // T6: ebreak at 8000_0008
    do_reset();
    eb_addr = 32'h8000_0008;
    rst = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (inst_valid && inst == 32'h0010_0073) found = 1'b1;
    end
    chk("t6_found", found, 1);
    chk("t6_eb_pc", inst_pc, 32'h8000_0008);
    tick();
`ifdef IFU_EBREAK_HALT_EN
    chk("t6_halted", halted, 1);
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_inst_valid", inst_valid, 0);
    n = iss.size();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    chk("t6_no_req", 32'(iss.size()), 32'(n));
    chk("t6_still_halted", halted, 1);
    chk("t6_still_idle", inst_valid, 0);
    do_reset();
    chk("t6_rst_halted", halted, 0);
`else
    chk("t6_not_halted", halted, 0);
    repeat (6) tick();
    n = con_pc.size();
    chk("t6_passed", 32'(n > 3), 1);
    chk("t6_con_pc2", con_pc[2], 32'h8000_0008);
    chk("t6_con_d2", con_d[2], 32'h0010_0073);
    chk("t6_con_pc3", con_pc[3], 32'h8000_000C);
    chk("t6_still_0", halted, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; producer of the 32-bit instruction word consumed by the decode/control stage.
- Keeps the fetch PC and issues in-order read requests to instruction memory.
- Buffers returned words in a small FIFO and presents them with their PC over a valid/ready handshake.
- Takes redirects (taken branch, jal, jalr) from execute and flushes wrong-path instructions.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, at least 2); also the maximum number of requests in flight plus buffered words.
- CPU_WIDTH, 32, address and instruction width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  CPU_WIDTH  fetch address, always 4-byte aligned.
- imem_rsp_valid  input  1  read data valid, in request order, at least 1 cycle after acceptance.
- imem_rsp_data  input  CPU_WIDTH  instruction word.
- redirect_valid  input  1  branch taken, jal or jalr resolved.
- redirect_pc  input  CPU_WIDTH  new fetch target.
- inst_valid  output  1  FIFO head holds an instruction.
- inst_ready  input  1  decode consumes the head.
- inst  output  CPU_WIDTH  head instruction word.
- inst_pc  output  CPU_WIDTH  PC of the head instruction.
- halted  output  1  fetch stopped (see optional feature).

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - Reset values: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
- Request side:
  - imem_req_addr = fetch_pc register.
  - imem_req_valid = !rst && !halted && (fifo_count + outstanding < FIFO_DEPTH). This credit rule guarantees every response has a free slot.
  - Request accepted when imem_req_valid && imem_req_ready: fetch_pc += 4, wrapping mod 2^32, and outstanding increments.
- Response side:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt != 0, the word is discarded and drop_cnt decrements.
  - Otherwise {data, pc} is pushed into the FIFO. The pc comes from a response-PC register that advances by 4 per accepted response.
  - An accept and a response in the same cycle leave outstanding unchanged.
- Output side:
  - inst_valid = (fifo_count != 0); inst and inst_pc are the registered head entry.
  - Pop on inst_valid && inst_ready.
  - Minimum latency is 2 cycles: request accepted in cycle N, response in cycle N+1, inst_valid in cycle N+2.
  - When inst_valid is 0, inst reads 0.
  - Push and pop in the same cycle on a full FIFO are legal; count is unchanged.
- Redirect, taking effect at the clock edge where redirect_valid=1:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}. Bits [1:0] are ignored.
  - The response-PC register is loaded with the same value.
  - FIFO is cleared. A pop in the same cycle still counts as consumed by decode.
  - drop_cnt <= outstanding-after-this-cycle. This includes a request accepted in the redirect cycle (issued at the old PC) and excludes a response arriving in the redirect cycle, which is discarded.
  - A second redirect while drop_cnt != 0 recomputes drop_cnt the same way. drop_cnt is never double-counted.
  - New requests may issue in the cycle after a redirect while drops are still pending.
- Reset mid-operation: all state returns to reset values. Responses arriving after reset for requests issued before reset are out of contract; the memory must be reset together with this unit.
- Without the optional feature, halted is tied to 0.

Optional Feature:
- Macro: IFU_EBREAK_HALT_EN.
- Defined:
  - When the head instruction 32'h0010_0073 (ebreak) is popped, halted is set on the next edge and stays 1 until rst.
  - While halted: imem_req_valid=0 and inst_valid=0. Remaining FIFO contents are discarded and later responses are dropped.
  - Redirects are ignored while halted.
- Not defined: halted is constant 0 and ebreak is passed through like any other word.

Test Plan:
- Reset then imem_req_ready=1, memory returning data one cycle after each request, inst_ready=1 → addresses 8000_0000, 8000_0004, 8000_0008; first inst_valid 2 cycles after the first accept, with inst_pc=8000_0000.
- inst_ready=0, memory always ready → exactly FIFO_DEPTH=2 requests issued and imem_req_valid=0 thereafter; raising inst_ready resumes fetch at 8000_0008 with no word lost or duplicated.
- 2 requests outstanding (8000_0010, 8000_0014), then redirect_valid with redirect_pc=8000_0101 → both responses dropped, next request addr 8000_0100, next inst_pc 8000_0100.
- Redirect in the same cycle as a request accept and a response arrival → the arriving response is discarded, the accepted old-PC response is dropped (drop_cnt=1), and the first delivered inst_pc equals the target.
- fetch_pc=FFFF_FFFC with request accepted → next imem_req_addr=0000_0000, and inst_pc values wrap identically.
- IFU_EBREAK_HALT_EN defined, memory returns 0010_0073 at 8000_0008 → halted=1 the cycle after its pop, no further requests, inst_valid=0 until rst.
